// File: rtl/ps2_dir_ctrl.sv
// PS/2 scan-code sequencer for the snake core: parses E0/F0 prefixes, filters
// typematic repeats and illegal turns, and queues up to two direction commands.
module ps2_dir_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned CNT_W       = 16,
    parameter logic [1:0]  INIT_DIR    = 2'b01
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_byte_i,
    input  logic       move_tick_i,
    output logic [1:0] cur_dir_o,
    output logic       paused_o,
    output logic [1:0] q_count_o,
    output logic       cmd_drop_o,
    output logic       prefix_err_o,
    output logic [1:0] parser_state_o
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_EXT     = 2'b01;
    localparam logic [1:0] ST_BRK     = 2'b10;
    localparam logic [1:0] ST_EXT_BRK = 2'b11;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             perr_q, perr_d;
    logic             make_ev, brk_ev, ev_ext;

    logic [8:0]       held_q, held_d;
    logic             held_v_q, held_v_d;
    logic             paused_q, paused_d;

    logic [1:0]       cur_q, cur_d;
    logic [1:0]       q0_q, q0_d, q1_q, q1_d;
    logic [1:0]       count_q, count_d;
    logic             drop_q, drop_d;

    logic [8:0]       key;
    logic             is_dir, is_space;
    logic [1:0]       dir;
    logic             make_new, tick_eff, cmd_ok;
    logic [1:0]       ref_dir;
    logic [1:0]       n_cnt;

    // Parser: only moves on received bytes; a stalled prefix times out back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        perr_d  = 1'b0;
        make_ev = 1'b0;
        brk_ev  = 1'b0;
        ev_ext  = 1'b0;
        if (rx_valid_i) begin
            cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte_i == 8'hE0)      state_d = ST_EXT;
                    else if (rx_byte_i == 8'hF0) state_d = ST_BRK;
                    else                         make_ev = 1'b1;
                end
                ST_EXT: begin
                    if (rx_byte_i == 8'hE0)      state_d = ST_EXT;
                    else if (rx_byte_i == 8'hF0) state_d = ST_EXT_BRK;
                    else begin
                        make_ev = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (rx_byte_i == 8'hE0) state_d = ST_EXT;
                    else begin
                        brk_ev  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    if (rx_byte_i == 8'hE0) state_d = ST_EXT;
                    else begin
                        brk_ev  = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == TIMEOUT_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                perr_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign key = {ev_ext, rx_byte_i};

    always_comb begin
        is_dir   = 1'b1;
        is_space = 1'b0;
        dir      = 2'b00;
        case (key)
            9'h01D, 9'h175: dir = 2'b00;
            9'h023, 9'h174: dir = 2'b01;
            9'h01B, 9'h172: dir = 2'b10;
            9'h01C, 9'h16B: dir = 2'b11;
            9'h029: begin
                is_dir   = 1'b0;
                is_space = 1'b1;
            end
            default: is_dir = 1'b0;
        endcase
    end

    // Any recognised make that is not a typematic repeat becomes the held key.
    assign make_new = make_ev && (is_dir || is_space) && !(held_v_q && (held_q == key));

    always_comb begin
        held_d   = held_q;
        held_v_d = held_v_q;
        if (make_new) begin
            held_d   = key;
            held_v_d = 1'b1;
        end else if (brk_ev && held_v_q && (held_q == key)) begin
            held_v_d = 1'b0;
        end
    end

    assign paused_d = paused_q ^ (make_new && is_space);
    assign tick_eff = move_tick_i && !paused_q;

    // Turn legality is judged against the newest pending direction, pre-pop.
    always_comb begin
        case (count_q)
            2'd0:    ref_dir = cur_q;
            2'd1:    ref_dir = q0_q;
            default: ref_dir = q1_q;
        endcase
    end

    assign cmd_ok = make_new && is_dir && !paused_q &&
                    (dir != ref_dir) && (dir != (ref_dir ^ 2'b10));

    always_comb begin
        cur_d   = cur_q;
        q0_d    = q0_q;
        q1_d    = q1_q;
        drop_d  = 1'b0;
        n_cnt   = count_q;
        if (tick_eff && (count_q != 2'd0)) begin
            cur_d = q0_q;
            q0_d  = q1_q;
            n_cnt = count_q - 2'd1;
        end
        if (cmd_ok) begin
            if (tick_eff && (count_q == 2'd0)) begin
                cur_d = dir;
            end else if (n_cnt == 2'd2) begin
                drop_d = 1'b1;
            end else if (n_cnt == 2'd0) begin
                q0_d  = dir;
                n_cnt = 2'd1;
            end else begin
                q1_d  = dir;
                n_cnt = 2'd2;
            end
        end
        count_d = n_cnt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            perr_q   <= 1'b0;
            held_q   <= '0;
            held_v_q <= 1'b0;
            paused_q <= 1'b0;
            cur_q    <= INIT_DIR;
            q0_q     <= 2'b00;
            q1_q     <= 2'b00;
            count_q  <= 2'd0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            perr_q   <= perr_d;
            held_q   <= held_d;
            held_v_q <= held_v_d;
            paused_q <= paused_d;
            cur_q    <= cur_d;
            q0_q     <= q0_d;
            q1_q     <= q1_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    assign cur_dir_o      = cur_q;
    assign paused_o       = paused_q;
    assign q_count_o      = count_q;
    assign cmd_drop_o     = drop_q;
    assign prefix_err_o   = perr_q;
    assign parser_state_o = state_q;

endmodule

// File: tb/tb_ps2_dir_ctrl.sv
// Directed, table-driven bench for ps2_dir_ctrl with hand-written sequences
// for prefix timeout and mid-operation reset.
module tb_ps2_dir_ctrl;

    localparam int unsigned TO = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       move_tick = 1'b0;
    logic [1:0] cur_dir;
    logic       paused;
    logic [1:0] q_count;
    logic       cmd_drop;
    logic       prefix_err;
    logic [1:0] parser_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rv;
        logic [7:0] b;
        logic       tick;
        logic [1:0] cur;
        logic       p;
        logic [1:0] q;
        logic       drop;
    } vec_t;

    vec_t vecs[$];

    ps2_dir_ctrl #(
        .TIMEOUT_CYC(TO),
        .CNT_W(16),
        .INIT_DIR(2'b01)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .rx_valid_i(rx_valid),
        .rx_byte_i(rx_byte),
        .move_tick_i(move_tick),
        .cur_dir_o(cur_dir),
        .paused_o(paused),
        .q_count_o(q_count),
        .cmd_drop_o(cmd_drop),
        .prefix_err_o(prefix_err),
        .parser_state_o(parser_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rv, input logic [7:0] b, input logic tick);
        rx_valid  = rv;
        rx_byte   = b;
        move_tick = tick;
        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
        move_tick = 1'b0;
    endtask

    task automatic add(input logic rv, input logic [7:0] b, input logic tick,
                       input logic [1:0] cur, input logic p, input logic [1:0] q,
                       input logic drop);
        vec_t v;
        v.rv = rv; v.b = b; v.tick = tick; v.cur = cur; v.p = p; v.q = q; v.drop = drop;
        vecs.push_back(v);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cur"}, 16'(cur_dir), 16'h1);
        chk({tag, "_paused"}, 16'(paused), 16'h0);
        chk({tag, "_qcnt"}, 16'(q_count), 16'h0);
        chk({tag, "_drop"}, 16'(cmd_drop), 16'h0);
        chk({tag, "_perr"}, 16'(prefix_err), 16'h0);
        chk({tag, "_state"}, 16'(parser_state), 16'h0);
    endtask

    initial begin
        int first_err;
        int pulses;

        // Basic make + tick, re-aim right
        add(1, 8'h1D, 0, 2'b01, 0, 2'd1, 0);
        add(0, 8'h00, 1, 2'b00, 0, 2'd0, 0);
        add(1, 8'h23, 0, 2'b00, 0, 2'd1, 0);
        add(0, 8'h00, 1, 2'b01, 0, 2'd0, 0);
        // Extended left while moving right: reversal, silently dropped
        add(1, 8'hE0, 0, 2'b01, 0, 2'd0, 0);
        add(1, 8'h6B, 0, 2'b01, 0, 2'd0, 0);
        // Typematic repeats, break, then duplicate
        add(1, 8'h1D, 0, 2'b01, 0, 2'd1, 0);
        add(0, 8'h00, 1, 2'b00, 0, 2'd0, 0);
        add(1, 8'h1D, 0, 2'b00, 0, 2'd0, 0);
        add(0, 8'h00, 1, 2'b00, 0, 2'd0, 0);
        add(1, 8'h1D, 0, 2'b00, 0, 2'd0, 0);
        add(1, 8'hF0, 0, 2'b00, 0, 2'd0, 0);
        add(1, 8'h1D, 0, 2'b00, 0, 2'd0, 0);
        add(1, 8'h1D, 0, 2'b00, 0, 2'd0, 0);
        add(1, 8'h23, 0, 2'b00, 0, 2'd1, 0);
        add(0, 8'h00, 1, 2'b01, 0, 2'd0, 0);
        // Fill queue, overflow drop, drain
        add(1, 8'hE0, 0, 2'b01, 0, 2'd0, 0);
        add(1, 8'h75, 0, 2'b01, 0, 2'd1, 0);
        add(1, 8'h1C, 0, 2'b01, 0, 2'd2, 0);
        add(1, 8'h1B, 0, 2'b01, 0, 2'd2, 1);
        add(0, 8'h00, 0, 2'b01, 0, 2'd2, 0);
        add(0, 8'h00, 1, 2'b00, 0, 2'd1, 0);
        add(0, 8'h00, 1, 2'b11, 0, 2'd0, 0);
        // Same-cycle push+tick with a full queue
        add(1, 8'h1D, 0, 2'b11, 0, 2'd1, 0);
        add(1, 8'h23, 0, 2'b11, 0, 2'd2, 0);
        add(1, 8'h1B, 1, 2'b00, 0, 2'd2, 0);
        add(0, 8'h00, 1, 2'b01, 0, 2'd1, 0);
        add(0, 8'h00, 1, 2'b10, 0, 2'd0, 0);
        // Same-cycle push+tick with empty queue: straight to cur_dir; reversal rejected
        add(1, 8'h1C, 1, 2'b11, 0, 2'd0, 0);
        add(1, 8'h23, 1, 2'b11, 0, 2'd0, 0);
        add(1, 8'h5A, 0, 2'b11, 0, 2'd0, 0);
        // Pause toggling
        add(1, 8'h29, 0, 2'b11, 1, 2'd0, 0);
        add(0, 8'h00, 1, 2'b11, 1, 2'd0, 0);
        add(1, 8'h1D, 0, 2'b11, 1, 2'd0, 0);
        add(0, 8'h00, 1, 2'b11, 1, 2'd0, 0);
        add(1, 8'hF0, 0, 2'b11, 1, 2'd0, 0);
        add(1, 8'h29, 0, 2'b11, 1, 2'd0, 0);
        add(1, 8'h29, 0, 2'b11, 0, 2'd0, 0);
        add(1, 8'h1B, 0, 2'b11, 0, 2'd1, 0);
        add(0, 8'h00, 1, 2'b10, 0, 2'd0, 0);
        // Extended break ignored; E0 restarting a break sequence
        add(1, 8'hE0, 0, 2'b10, 0, 2'd0, 0);
        add(1, 8'hF0, 0, 2'b10, 0, 2'd0, 0);
        add(1, 8'h72, 0, 2'b10, 0, 2'd0, 0);
        add(1, 8'hF0, 0, 2'b10, 0, 2'd0, 0);
        add(1, 8'hE0, 0, 2'b10, 0, 2'd0, 0);
        add(1, 8'h6B, 0, 2'b10, 0, 2'd1, 0);
        add(0, 8'h00, 1, 2'b11, 0, 2'd0, 0);

        // Clock/reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].rv, vecs[i].b, vecs[i].tick);
            chk($sformatf("v%0d_cur", i), 16'(cur_dir), 16'(vecs[i].cur));
            chk($sformatf("v%0d_paused", i), 16'(paused), 16'(vecs[i].p));
            chk($sformatf("v%0d_qcnt", i), 16'(q_count), 16'(vecs[i].q));
            chk($sformatf("v%0d_drop", i), 16'(cmd_drop), 16'(vecs[i].drop));
            chk($sformatf("v%0d_perr", i), 16'(prefix_err), 16'h0);
        end

        // Mid-operation reset with full queue and parser in EXT_BRK
        step(1, 8'h1D, 0);
        step(1, 8'h23, 0);
        step(1, 8'hE0, 0);
        step(1, 8'hF0, 0);
        chk("pre_rst_qcnt", 16'(q_count), 16'h2);
        chk("pre_rst_state", 16'(parser_state), 16'h3);
        rst_n = 1'b0;
        step(0, 8'h00, 0);
        check_reset_vals("midrst");
        rst_n = 1'b1;

        // Prefix timeout: E0 then silence
        step(1, 8'hE0, 0);
        chk("to_state_ext", 16'(parser_state), 16'h1);
        first_err = 0;
        pulses    = 0;
        for (int i = 1; i <= int'(TO) + 8; i++) begin
            step(0, 8'h00, 0);
            if (prefix_err) begin
                pulses++;
                if (first_err == 0) first_err = i;
            end
        end
        chk("to_latency", 16'(first_err), 16'(TO));
        chk("to_pulse_width", 16'(pulses), 16'h1);
        chk("to_state_idle", 16'(parser_state), 16'h0);
        step(1, 8'h1D, 0);
        chk("after_to_qcnt", 16'(q_count), 16'h1);
        step(0, 8'h00, 1);
        chk("after_to_cur", 16'(cur_dir), 16'h0);
        chk("after_to_qcnt0", 16'(q_count), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
